// File: rtl/axi_burst_master_pkg.sv
// axi_burst_master_pkg: shared AXI constants, error-flag bit positions and
// burst-length limits for the burst master and its length FIFO.
package axi_burst_master_pkg;

    localparam logic [2:0] SIZE_64B   = 3'd6;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam int ERR_W       = 4;
    localparam int ERR_RRESP   = 0;
    localparam int ERR_BRESP   = 1;
    localparam int ERR_WLAST   = 2;
    localparam int ERR_RORPHAN = 3;

    localparam logic [7:0] MAX_BURST_LEN = 8'd63;

endpackage

// File: rtl/axi_burst_master_len_fifo.sv
// burst_len_fifo: synchronous FIFO of AW burst lengths, used to check wlast.
// Ports: push_i/data_i write, pop_i retire, head_o oldest entry, empty_o/full_o.
module burst_len_fifo
    import axi_burst_master_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/axi_burst_master.sv
// axi_burst_master: bridges simple read/write burst requests to an AXI4 master.
// Ports: rd_* / data_* read request and beat stream, wr_* / data_out write
// request and beat stream, m_axi_* AXI4 channels, idle flags and sticky err.
module axi_burst_master
    import axi_burst_master_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int MAX_RD_OUTSTANDING = 16,
    parameter int MAX_WR_OUTSTANDING = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            rd_req,
    input  logic [7:0]                      rd_len,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   rd_address,
    output logic                            rd_req_ack,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   data_in,
    output logic                            valid_in,
    output logic                            rd_last,
    input  logic                            data_ready,
    input  logic                            wr_req,
    input  logic [7:0]                      wr_len,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   wr_address,
    output logic                            wr_req_ack,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   data_out,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] byte_valid_out,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic                            wr_data_last,
    input  logic                            bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]                      m_axi_arlen,
    output logic [2:0]                      m_axi_arsize,
    output logic [1:0]                      m_axi_arburst,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rlast,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                      m_axi_awlen,
    output logic [2:0]                      m_axi_awsize,
    output logic [1:0]                      m_axi_awburst,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wlast,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    output logic                            rd_idle,
    output logic                            wr_idle,
    output logic [ERR_W-1:0]                err
);

    localparam int RCW = $clog2(MAX_RD_OUTSTANDING + 1);
    localparam int WCW = $clog2(MAX_WR_OUTSTANDING + 1);
    localparam int AW  = C_M_AXI_ADDR_WIDTH;
    localparam int DW  = C_M_AXI_DATA_WIDTH;

    // ---------------- AR channel ----------------
    logic          ar_valid_q, ar_valid_d;
    logic [AW-1:0] ar_addr_q, ar_addr_d;
    logic [7:0]    ar_len_q, ar_len_d;
    logic [2:0]    ar_size_q, ar_size_d;
    logic [1:0]    ar_burst_q, ar_burst_d;
    logic [RCW-1:0] rd_out_q, rd_out_d;
    logic          ar_hs;
    logic          rd_capture;

    // ---------------- R path ----------------
    logic [DW-1:0] rdata_q;
    logic          rvalid_q;
    logic          rlast_q;
    logic          r_hs;
    logic          r_last_hs;

    // ---------------- AW / W / B ----------------
    logic          aw_valid_q, aw_valid_d;
    logic [AW-1:0] aw_addr_q, aw_addr_d;
    logic [7:0]    aw_len_q, aw_len_d;
    logic [2:0]    aw_size_q, aw_size_d;
    logic [1:0]    aw_burst_q, aw_burst_d;
    logic [WCW-1:0] wr_out_q, wr_out_d;
    logic [WCW-1:0] credit_q, credit_d;
    logic [7:0]    beat_q, beat_d;
    logic          aw_hs;
    logic          wr_capture;
    logic          w_hs;
    logic          w_last_hs;
    logic          b_hs;
    logic          credit_ok;
    logic [7:0]    fifo_head;
    logic          fifo_empty;
    logic          fifo_full;
    logic          wlast_bad;

    logic [ERR_W-1:0] err_q, err_d;

    // ---------------- read side ----------------
    assign ar_hs      = ar_valid_q & m_axi_arready;
    assign rd_req_ack = ar_hs;
    // The ack-cycle term keeps a still-held request from being re-captured.
    assign rd_capture = rd_req & ~ar_valid_q & ~ar_hs
                      & (rd_out_q < RCW'(MAX_RD_OUTSTANDING));

    always_comb begin
        ar_valid_d = ar_valid_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        if (ar_hs) begin
            ar_valid_d = 1'b0;
        end
        if (rd_capture) begin
            ar_valid_d = 1'b1;
            ar_addr_d  = rd_address;
            // Reads never exceed the decompressor's 64-beat burst.
            ar_len_d   = (rd_len > MAX_BURST_LEN) ? MAX_BURST_LEN : rd_len;
            ar_size_d  = SIZE_64B;
            ar_burst_d = BURST_INCR;
        end
    end

    assign m_axi_rready = data_ready;
    assign r_hs         = m_axi_rvalid & data_ready;
    assign r_last_hs    = r_hs & m_axi_rlast;

    always_comb begin
        rd_out_d = rd_out_q;
        unique case ({ar_hs, r_last_hs & (rd_out_q != '0)})
            2'b10:   rd_out_d = rd_out_q + 1'b1;
            2'b01:   rd_out_d = rd_out_q - 1'b1;
            default: rd_out_d = rd_out_q;
        endcase
    end

    // ---------------- write side ----------------
    assign aw_hs      = aw_valid_q & m_axi_awready;
    assign wr_req_ack = aw_hs;
    assign wr_capture = wr_req & ~aw_valid_q & ~aw_hs & ~fifo_full
                      & (wr_out_q < WCW'(MAX_WR_OUTSTANDING));

    always_comb begin
        aw_valid_d = aw_valid_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        aw_burst_d = aw_burst_q;
        if (aw_hs) begin
            aw_valid_d = 1'b0;
        end
        if (wr_capture) begin
            aw_valid_d = 1'b1;
            aw_addr_d  = wr_address;
            aw_len_d   = wr_len;
            aw_size_d  = SIZE_64B;
            aw_burst_d = BURST_INCR;
        end
    end

    // W beats may only flow for bursts whose address has been accepted.
    assign credit_ok    = (credit_q != '0);
    assign m_axi_wvalid = wr_valid & credit_ok;
    assign wr_ready     = m_axi_wready & credit_ok;
    assign m_axi_wdata  = data_out;
    assign m_axi_wstrb  = byte_valid_out;
    assign m_axi_wlast  = wr_data_last;
    assign w_hs         = m_axi_wvalid & m_axi_wready;
    assign w_last_hs    = w_hs & wr_data_last;

    assign m_axi_bready = bready;
    assign b_hs         = m_axi_bvalid & bready;

    burst_len_fifo #(
        .DEPTH (MAX_WR_OUTSTANDING),
        .WIDTH (8)
    ) u_len_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (aw_hs),
        .data_i  (aw_len_q),
        .pop_i   (w_last_hs),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Beat counter is compared against awlen (beats - 1) of the oldest burst.
    assign wlast_bad = w_hs & (fifo_empty
                     | (wr_data_last ? (beat_q != fifo_head)
                                     : (beat_q == fifo_head)));

    always_comb begin
        beat_d   = beat_q;
        credit_d = credit_q;
        wr_out_d = wr_out_q;
        if (w_hs) begin
            beat_d = wr_data_last ? 8'd0 : beat_q + 1'b1;
        end
        unique case ({aw_hs, w_last_hs & credit_ok})
            2'b10:   credit_d = credit_q + 1'b1;
            2'b01:   credit_d = credit_q - 1'b1;
            default: credit_d = credit_q;
        endcase
        unique case ({aw_hs, b_hs & (wr_out_q != '0)})
            2'b10:   wr_out_d = wr_out_q + 1'b1;
            2'b01:   wr_out_d = wr_out_q - 1'b1;
            default: wr_out_d = wr_out_q;
        endcase
    end

    // ---------------- sticky errors ----------------
    always_comb begin
        err_d = err_q;
        if (r_hs && m_axi_rresp != RESP_OKAY) begin
            err_d[ERR_RRESP] = 1'b1;
        end
        if (r_hs && rd_out_q == '0) begin
            err_d[ERR_RORPHAN] = 1'b1;
        end
        if (b_hs && m_axi_bresp != RESP_OKAY) begin
            err_d[ERR_BRESP] = 1'b1;
        end
        if (wlast_bad) begin
            err_d[ERR_WLAST] = 1'b1;
        end
    end

    // ---------------- state ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            rd_out_q   <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            aw_valid_q <= 1'b0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            wr_out_q   <= '0;
            credit_q   <= '0;
            beat_q     <= '0;
            err_q      <= '0;
        end else begin
            ar_valid_q <= ar_valid_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            rd_out_q   <= rd_out_d;
            if (r_hs) begin
                rdata_q <= m_axi_rdata;
            end
            rvalid_q   <= r_hs;
            rlast_q    <= r_last_hs;
            aw_valid_q <= aw_valid_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            wr_out_q   <= wr_out_d;
            credit_q   <= credit_d;
            beat_q     <= beat_d;
            err_q      <= err_d;
        end
    end

    // ---------------- outputs ----------------
    assign m_axi_araddr  = ar_addr_q;
    assign m_axi_arlen   = ar_len_q;
    assign m_axi_arsize  = ar_size_q;
    assign m_axi_arburst = ar_burst_q;
    assign m_axi_arvalid = ar_valid_q;

    assign m_axi_awaddr  = aw_addr_q;
    assign m_axi_awlen   = aw_len_q;
    assign m_axi_awsize  = aw_size_q;
    assign m_axi_awburst = aw_burst_q;
    assign m_axi_awvalid = aw_valid_q;

    assign data_in  = rdata_q;
    assign valid_in = rvalid_q;
    assign rd_last  = rlast_q;

    assign rd_idle = (rd_out_q == '0) & ~ar_valid_q;
    assign wr_idle = (wr_out_q == '0) & ~aw_valid_q;
    assign err     = err_q;

endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: directed, table-driven bench for axi_burst_master.
// Read outstanding limit 2, write outstanding limit 4.
module tb_axi_burst_master;

    localparam int AW = 64;
    localparam int DW = 512;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_req;
    logic [7:0]    rd_len;
    logic [AW-1:0] rd_address;
    logic          rd_req_ack;
    logic [DW-1:0] data_in;
    logic          valid_in;
    logic          rd_last;
    logic          data_ready;
    logic          wr_req;
    logic [7:0]    wr_len;
    logic [AW-1:0] wr_address;
    logic          wr_req_ack;
    logic [DW-1:0] data_out;
    logic [SW-1:0] byte_valid_out;
    logic          wr_valid;
    logic          wr_ready;
    logic          wr_data_last;
    logic          bready;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic [AW-1:0] m_axi_awaddr;
    logic [7:0]    m_axi_awlen;
    logic [2:0]    m_axi_awsize;
    logic [1:0]    m_axi_awburst;
    logic          m_axi_awvalid;
    logic          m_axi_awready;
    logic [DW-1:0] m_axi_wdata;
    logic [SW-1:0] m_axi_wstrb;
    logic          m_axi_wlast;
    logic          m_axi_wvalid;
    logic          m_axi_wready;
    logic [1:0]    m_axi_bresp;
    logic          m_axi_bvalid;
    logic          m_axi_bready;
    logic          rd_idle;
    logic          wr_idle;
    logic [3:0]    err;

    int errors = 0;
    int checks = 0;
    int ack_cnt = 0;
    int vin_cnt = 0;
    int last_cnt = 0;
    int last_at = 0;

    axi_burst_master #(
        .C_M_AXI_ADDR_WIDTH (AW),
        .C_M_AXI_DATA_WIDTH (DW),
        .MAX_RD_OUTSTANDING (2),
        .MAX_WR_OUTSTANDING (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rd_req         (rd_req),
        .rd_len         (rd_len),
        .rd_address     (rd_address),
        .rd_req_ack     (rd_req_ack),
        .data_in        (data_in),
        .valid_in       (valid_in),
        .rd_last        (rd_last),
        .data_ready     (data_ready),
        .wr_req         (wr_req),
        .wr_len         (wr_len),
        .wr_address     (wr_address),
        .wr_req_ack     (wr_req_ack),
        .data_out       (data_out),
        .byte_valid_out (byte_valid_out),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_data_last   (wr_data_last),
        .bready         (bready),
        .m_axi_araddr   (m_axi_araddr),
        .m_axi_arlen    (m_axi_arlen),
        .m_axi_arsize   (m_axi_arsize),
        .m_axi_arburst  (m_axi_arburst),
        .m_axi_arvalid  (m_axi_arvalid),
        .m_axi_arready  (m_axi_arready),
        .m_axi_rdata    (m_axi_rdata),
        .m_axi_rresp    (m_axi_rresp),
        .m_axi_rlast    (m_axi_rlast),
        .m_axi_rvalid   (m_axi_rvalid),
        .m_axi_rready   (m_axi_rready),
        .m_axi_awaddr   (m_axi_awaddr),
        .m_axi_awlen    (m_axi_awlen),
        .m_axi_awsize   (m_axi_awsize),
        .m_axi_awburst  (m_axi_awburst),
        .m_axi_awvalid  (m_axi_awvalid),
        .m_axi_awready  (m_axi_awready),
        .m_axi_wdata    (m_axi_wdata),
        .m_axi_wstrb    (m_axi_wstrb),
        .m_axi_wlast    (m_axi_wlast),
        .m_axi_wvalid   (m_axi_wvalid),
        .m_axi_wready   (m_axi_wready),
        .m_axi_bresp    (m_axi_bresp),
        .m_axi_bvalid   (m_axi_bvalid),
        .m_axi_bready   (m_axi_bready),
        .rd_idle        (rd_idle),
        .wr_idle        (wr_idle),
        .err            (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rd_req_ack) ack_cnt++;
        if (valid_in) begin
            vin_cnt++;
            if (rd_last) begin
                last_cnt++;
                last_at = vin_cnt;
            end
        end
    end

    typedef struct {
        logic       dr;
        logic       rv;
        logic       rl;
        logic [7:0] d;
        logic       e_rr;
        logic       e_v;
        logic       e_l;
    } rvec_t;

    rvec_t tbl [8];

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [7:0] b);
        return {SW{b}};
    endfunction

    task automatic rd_issue(input logic [AW-1:0] a, input logic [7:0] l);
        bit got = 0;
        rd_address = a;
        rd_len = l;
        rd_req = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rd_req_ack) begin
                got = 1;
                chk("ar_addr", DW'(m_axi_araddr), DW'(a));
                chk("ar_len", DW'(m_axi_arlen), DW'(l));
            end
        end
        chk("rd_ack_seen", DW'(got), DW'(1));
        @(posedge clk);
        #1 rd_req = 1'b0;
    endtask

    task automatic wr_issue(input logic [AW-1:0] a, input logic [7:0] l);
        bit got = 0;
        wr_address = a;
        wr_len = l;
        wr_req = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (wr_req_ack) begin
                got = 1;
                chk("aw_addr", DW'(m_axi_awaddr), DW'(a));
                chk("aw_len", DW'(m_axi_awlen), DW'(l));
                chk("aw_size", DW'(m_axi_awsize), DW'(3'd6));
            end
        end
        chk("wr_ack_seen", DW'(got), DW'(1));
        @(posedge clk);
        #1 wr_req = 1'b0;
    endtask

    task automatic w_beat(input logic [7:0] d, input logic last);
        wr_valid = 1'b1;
        data_out = pat(d);
        wr_data_last = last;
        @(negedge clk);
        chk("w_ready", DW'(wr_ready), DW'(1));
        chk("w_data", m_axi_wdata, pat(d));
        chk("w_last", DW'(m_axi_wlast), DW'(last));
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_data_last = 1'b0;
    endtask

    task automatic b_send(input logic [1:0] r);
        m_axi_bvalid = 1'b1;
        m_axi_bresp = r;
        @(posedge clk);
        #1;
        m_axi_bvalid = 1'b0;
        m_axi_bresp = 2'b00;
    endtask

    task automatic r_beat(input logic [7:0] d, input logic last);
        m_axi_rvalid = 1'b1;
        m_axi_rdata = pat(d);
        m_axi_rlast = last;
        @(posedge clk);
        #1;
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit issued;
        rst_n = 1'b0;
        rd_req = 0; rd_len = 0; rd_address = 0;
        data_ready = 1'b1;
        wr_req = 0; wr_len = 0; wr_address = 0;
        data_out = 0; byte_valid_out = '1;
        wr_valid = 0; wr_data_last = 0;
        bready = 1'b1;
        m_axi_arready = 0; m_axi_rdata = 0; m_axi_rresp = 0;
        m_axi_rlast = 0; m_axi_rvalid = 0;
        m_axi_awready = 0; m_axi_wready = 0;
        m_axi_bresp = 0; m_axi_bvalid = 0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_idle", DW'(rd_idle), DW'(1));
        chk("rst_wr_idle", DW'(wr_idle), DW'(1));
        chk("rst_arvalid", DW'(m_axi_arvalid), DW'(0));
        chk("rst_awvalid", DW'(m_axi_awvalid), DW'(0));
        chk("rst_err", DW'(err), DW'(0));
        chk("rst_valid_in", DW'(valid_in), DW'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 64-beat read burst, arready two cycles late
        rd_len = 8'd63;
        rd_address = 64'h1000;
        rd_req = 1'b1;
        ack_cnt = 0;
        @(posedge clk);
        #1;
        chk("ar_valid", DW'(m_axi_arvalid), DW'(1));
        chk("ar_addr0", DW'(m_axi_araddr), DW'(64'h1000));
        chk("ar_len0", DW'(m_axi_arlen), DW'(63));
        chk("ar_size", DW'(m_axi_arsize), DW'(6));
        chk("ar_burst", DW'(m_axi_arburst), DW'(1));
        @(posedge clk);
        #1;
        chk("ar_hold", DW'(m_axi_arvalid), DW'(1));
        m_axi_arready = 1'b1;
        @(negedge clk);
        chk("rd_ack", DW'(rd_req_ack), DW'(1));
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        chk("ar_drop", DW'(m_axi_arvalid), DW'(0));
        repeat (2) @(posedge clk);
        #1;
        chk("ack_once", DW'(ack_cnt), DW'(1));
        vin_cnt = 0; last_cnt = 0; last_at = 0;
        for (int i = 0; i < 64; i++) r_beat(8'(i), i == 63);
        @(posedge clk);
        #1;
        chk("rd_beats", DW'(vin_cnt), DW'(64));
        chk("rd_last_cnt", DW'(last_cnt), DW'(1));
        chk("rd_last_pos", DW'(last_at), DW'(64));
        chk("rd_last_data", data_in, pat(8'd63));
        chk("rd_idle_back", DW'(rd_idle), DW'(1));

        // outstanding limit of two
        rd_issue(64'h3000, 8'd0);
        rd_issue(64'h3040, 8'd0);
        rd_address = 64'h3080;
        rd_len = 8'd0;
        rd_req = 1'b1;
        issued = 0;
        repeat (4) begin
            @(negedge clk);
            if (m_axi_arvalid) issued = 1;
        end
        @(posedge clk);
        #1;
        chk("ar_withheld", DW'(issued), DW'(0));
        r_beat(8'h11, 1'b1);
        rd_issue(64'h3080, 8'd0);
        r_beat(8'h22, 1'b1);
        r_beat(8'h33, 1'b1);
        @(negedge clk);
        chk("lim_rd_idle", DW'(rd_idle), DW'(1));
        chk("lim_err", DW'(err), DW'(0));
        @(posedge clk);
        #1;

        // backpressure table on a 4-beat burst
        tbl[0] = '{1'b1, 1'b1, 1'b0, 8'hA0, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 8'hA1, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 8'hEE, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 8'hA2, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b1};
        rd_issue(64'h2000, 8'd3);
        for (int i = 0; i < 8; i++) begin
            data_ready = tbl[i].dr;
            m_axi_rvalid = tbl[i].rv;
            m_axi_rlast = tbl[i].rl;
            m_axi_rdata = pat(tbl[i].d);
            @(negedge clk);
            chk($sformatf("bp_rready[%0d]", i), DW'(m_axi_rready),
                DW'(tbl[i].e_rr));
            @(posedge clk);
            #1;
            chk($sformatf("bp_vin[%0d]", i), DW'(valid_in), DW'(tbl[i].e_v));
            chk($sformatf("bp_last[%0d]", i), DW'(rd_last), DW'(tbl[i].e_l));
            if (tbl[i].e_v) begin
                chk($sformatf("bp_data[%0d]", i), data_in, pat(tbl[i].d));
            end
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
        data_ready = 1'b1;
        @(negedge clk);
        chk("bp_rd_idle", DW'(rd_idle), DW'(1));
        @(posedge clk);
        #1;

        // write credit gating
        m_axi_wready = 1'b1;
        wr_valid = 1'b1;
        data_out = pat(8'h55);
        @(negedge clk);
        chk("nocredit_ready", DW'(wr_ready), DW'(0));
        chk("nocredit_wvalid", DW'(m_axi_wvalid), DW'(0));
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        m_axi_awready = 1'b1;
        wr_issue(64'h4000, 8'd3);
        for (int i = 0; i < 4; i++) w_beat(8'(8'h40 + i), i == 3);
        wr_valid = 1'b1;
        @(negedge clk);
        chk("credit_spent", DW'(wr_ready), DW'(0));
        chk("wr_busy", DW'(wr_idle), DW'(0));
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        b_send(2'b00);
        @(negedge clk);
        chk("wr_idle_back", DW'(wr_idle), DW'(1));
        chk("wr_err_clean", DW'(err), DW'(0));
        @(posedge clk);
        #1;

        // wlast on beat 2 of a 4-beat burst, then a good burst
        wr_issue(64'h5000, 8'd3);
        w_beat(8'h50, 1'b0);
        w_beat(8'h51, 1'b1);
        @(negedge clk);
        chk("wlast_err", DW'(err), DW'(4'b0100));
        @(posedge clk);
        #1;
        b_send(2'b00);
        wr_issue(64'h5100, 8'd1);
        w_beat(8'h60, 1'b0);
        w_beat(8'h61, 1'b1);
        b_send(2'b00);
        @(negedge clk);
        chk("wlast_sticky", DW'(err), DW'(4'b0100));
        @(posedge clk);
        #1;

        // B error response
        wr_issue(64'h6000, 8'd0);
        w_beat(8'h70, 1'b1);
        b_send(2'b10);
        @(negedge clk);
        chk("bresp_err", DW'(err), DW'(4'b0110));
        @(posedge clk);
        #1;

        // AW and B handshakes in the same cycle
        wr_issue(64'h6100, 8'd0);
        m_axi_awready = 1'b0;
        wr_address = 64'h6200;
        wr_len = 8'd0;
        wr_req = 1'b1;
        @(posedge clk);
        #1;
        chk("sim_awvalid", DW'(m_axi_awvalid), DW'(1));
        m_axi_awready = 1'b1;
        m_axi_bvalid = 1'b1;
        @(negedge clk);
        chk("sim_aw_ack", DW'(wr_req_ack), DW'(1));
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        m_axi_bvalid = 1'b0;
        @(negedge clk);
        chk("sim_out_kept", DW'(wr_idle), DW'(0));
        @(posedge clk);
        #1;
        b_send(2'b00);
        @(negedge clk);
        chk("sim_one_b", DW'(wr_idle), DW'(1));
        @(posedge clk);
        #1;

        // R beat with nothing outstanding, with an error response
        m_axi_rresp = 2'b10;
        r_beat(8'h99, 1'b1);
        m_axi_rresp = 2'b00;
        @(negedge clk);
        chk("orphan_rresp", DW'(err), DW'(4'b1111));
        @(posedge clk);
        #1;

        // asynchronous reset clears everything
        rst_n = 1'b0;
        #1;
        chk("arst_err", DW'(err), DW'(0));
        chk("arst_rd_idle", DW'(rd_idle), DW'(1));
        chk("arst_wr_idle", DW'(wr_idle), DW'(1));
        chk("arst_wr_ready", DW'(wr_ready), DW'(0));
        chk("arst_valid_in", DW'(valid_in), DW'(0));
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_burst_master.md
# axi_burst_master

Bridges the decompressor's simple burst-request interface to an AXI4 master port. On the read side it turns `rd_req`/`rd_len`/`rd_address` into AR bursts and returns R beats as `data_in`/`valid_in`/`rd_last`, throttled by `data_ready`. On the write side it turns `wr_req`/`wr_len`/`wr_address` into AW bursts and forwards the output-FIFO stream onto W, gated by issued-address credit. It also tracks B responses, enforces outstanding-transaction limits and reports sticky protocol errors.

## Interface
- C_M_AXI_ADDR_WIDTH, 64, AXI address width
- C_M_AXI_DATA_WIDTH, 512, AXI data width (beat = 64 B)
- MAX_RD_OUTSTANDING, 16, maximum AR bursts awaiting `rlast`
- MAX_WR_OUTSTANDING, 16, maximum AW bursts awaiting a B response; also the depth of the write-length FIFO
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- rd_req  in  1  read burst request, held until acknowledged
- rd_len  in  8  beats − 1 (≤ 63)
- rd_address  in  64  burst start address
- rd_req_ack  out  1  one-cycle pulse on AR handshake
- data_in  out  512  read beat data
- valid_in  out  1  read beat valid
- rd_last  out  1  last beat of a read burst
- data_ready  in  1  consumer can accept read beats
- wr_req  in  1  write burst request, held until acknowledged
- wr_len  in  8  beats − 1
- wr_address  in  64  burst start address
- wr_req_ack  out  1  one-cycle pulse on AW handshake
- data_out  in  512  write beat data
- byte_valid_out  in  64  write strobes
- wr_valid  in  1  write beat valid
- wr_ready  out  1  write beat accepted
- wr_data_last  in  1  last beat of a write burst
- bready  in  1  consumer accepts B responses
- m_axi_ar{addr,len,size,burst,valid}  out  64/8/3/2/1  AR channel
- m_axi_arready  in  1  AR channel ready
- m_axi_r{data,resp,last,valid}  in  512/2/1/1  R channel
- m_axi_rready  out  1  R channel ready
- m_axi_aw{addr,len,size,burst,valid}  out  64/8/3/2/1  AW channel
- m_axi_awready  in  1  AW channel ready
- m_axi_w{data,strb,last,valid}  out  512/64/1/1  W channel
- m_axi_wready  in  1  W channel ready
- m_axi_b{resp,valid}  in  2/1  B channel
- m_axi_bready  out  1  B channel ready
- rd_idle, wr_idle  out  1 each  no read / no write activity
- err  out  4  sticky error flags: [0] rresp≠0, [1] bresp≠0, [2] wlast mismatch, [3] R beat with no read outstanding

## Operation
- **AR issue.** Capture `rd_req` fields only when all three hold: `arvalid`=0, no `rd_req_ack` in this cycle, and `rd_outstanding` < MAX_RD_OUTSTANDING. The capture sets `arvalid` at the next edge.
  - `arsize`=3'd6, `arburst`=2'b01, ID fixed at 0.
  - `arvalid` and its fields hold until `arready`.
  - `rd_req_ack` = `arvalid & arready`.
- **rd_outstanding.** +1 on AR handshake, −1 on the R handshake carrying `rlast`. When both occur in the same cycle, the count is unchanged. Saturation is never reached because issue is blocked at MAX.
- **R path.**
  - `m_axi_rready` = `data_ready`.
  - Registered on each R handshake: `data_in`←`rdata`, `valid_in`←1, `rd_last`←`rlast`. Otherwise `valid_in`=0 and `rd_last`=0.
  - `rresp`≠0 sets err[0].
  - A handshake while `rd_outstanding`=0 sets err[3].
- **AW issue.** Same capture and hold rules as AR, using `wr_outstanding` < MAX_WR_OUTSTANDING.
- **w_credit.** +1 on AW handshake, −1 on a W handshake with `wlast`.
- **W path (combinational).**
  - `m_axi_wvalid` = `wr_valid & (w_credit≠0)`.
  - `wr_ready` = `m_axi_wready & (w_credit≠0)`.
  - `wdata`/`wstrb`/`wlast` are driven directly from `data_out`/`byte_valid_out`/`wr_data_last`.
- **wlast check.** On each AW handshake, push `awlen` into the length FIFO. A beat counter counts W handshakes.
  - err[2] is set if `wlast` arrives with counter ≠ head, or counter = head without `wlast`.
  - Either way, at `wlast` the FIFO pops and the counter clears.
- **B path.**
  - `m_axi_bready` = `bready`.
  - `wr_outstanding`: +1 on AW handshake, −1 on B handshake; unchanged when both occur together.
  - `bresp`≠0 sets err[1].
- **Idle flags.**
  - `rd_idle` = (`rd_outstanding`=0) & ~`arvalid`.
  - `wr_idle` = (`wr_outstanding`=0) & ~`awvalid`.

## Timing
- **Reset values.** All outputs are 0, except `rd_idle`=1 and `wr_idle`=1. Counters, FIFO and err are cleared.
- **Latency.**
  - `rd_req` high → `arvalid` at the next edge.
  - R handshake → `valid_in` one cycle later.
  - W path has zero latency.
- **Request release.** The requester drops `rd_req`/`wr_req` on the edge after the ack. The no-capture-in-ack-cycle rule prevents a duplicate issue.
- **Read backpressure.** `data_ready` deasserting stops R beats on the same cycle. The consumer budgets the 1-cycle registered skid.
- **Reset mid-operation.** Assertion is asynchronous; outstanding bursts are abandoned. The AXI slave is reset by the same `rst_n`.

## Structure
- Shared package holds: AXI constants (SIZE_64B=3'd6, BURST_INCR=2'b01, RESP_OKAY=2'b00), the err bit indices, and the max burst length of 63.
- One sub-module, `burst_len_fifo`: synchronous FIFO, depth MAX_WR_OUTSTANDING, 8-bit, with push/pop/head/empty.

## Test plan
- **Read burst.** `rd_req` len=63, addr 0x1000, `arready` after 2 cycles → `araddr`=0x1000, `arlen`=63, `arsize`=6, `arburst`=1, single `rd_req_ack`. 64 R beats → 64 `valid_in`, `rd_last` only on the 64th. `rd_idle` returns to 1.
- **Read outstanding limit.** MAX_RD_OUTSTANDING=2, three back-to-back requests, no R data → third AR withheld until the first `rlast` handshake, then issued.
- **Read backpressure.** `data_ready`=0 with `rvalid`=1 → `rready`=0 and no `valid_in`. Release → beats resume in order.
- **Write credit gating.** `wr_valid`=1 before any AW → `wr_ready`=0 and `wvalid`=0. After AW len=3 handshake, 4 beats pass with `wlast` on the 4th; then `wr_ready`=0. B OKAY → `wr_idle`=1.
- **wlast mismatch.** `wr_data_last` on beat 2 of a len=3 burst → err[2]=1, held through subsequent good bursts until reset.
- **B error and simultaneous events.** `bresp`=2'b10 → err[1]=1. AW handshake and B handshake in the same cycle → `wr_outstanding` unchanged.
